uut_gate: RTL and testbench
===========================

Name: uut_gate

Overview:
- Two-input logic gate with a combinational output `out` and a clocked observation path.
- The observation path provides a registered output, single-cycle rise/fall pulses and a saturating toggle counter.
- Used as the device under test for gate-level simulation. `out` carries rise/fall path delays, simulation only.
- Sits standalone, or as a leaf gate inside larger gate-level netlists.

Parameters:
- FUNC, 0, gate function: 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR; any other value behaves as AND.
- T_RISE, 2, out 0->1 propagation delay in ns, from either input; simulation only, ignored by synthesis.
- T_FALL, 3, out 1->0 propagation delay in ns, from either input; simulation only, ignored by synthesis.
- CNT_W, 8, width of toggle_cnt.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  reset, active-low, asynchronous.
- a  in  1  gate input A.
- b  in  1  gate input B.
- out  out  1  combinational gate output, delayed by T_RISE/T_FALL in simulation.
- out_q  out  1  registered gate output.
- rise  out  1  one-cycle pulse when out_q goes 0->1.
- fall  out  1  one-cycle pulse when out_q goes 1->0.
- toggle_cnt  out  CNT_W  count of out_q transitions since reset; saturating.

Interface (already decided): one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Gate function f(a,b):
  - Selected by FUNC. Default AND truth table for {a,b} = 00,01,10,11 is 0,0,0,1.
- out (combinational path):
  - out = f(a,b), independent of clk and rst_n; out is not affected by reset.
  - Simulation delay applies from both a and b: T_RISE when out goes 0->1, T_FALL when it goes 1->0.
  - The delay is inertial: an input pulse shorter than the applicable delay produces no out change.
  - X or Z on any input yields X on out.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_q=0, rise=0, fall=0, toggle_cnt=0.
  - Release is synchronous in effect: the first update happens at the first rising clk edge with rst_n high.
- Each rising clk edge with rst_n high:
  - out_q <= f(a,b), using undelayed inputs; latency from input change to out_q is 1 clock edge.
  - rise <= f(a,b) & ~out_q.
  - fall <= ~f(a,b) & out_q.
  - rise/fall are therefore high during the first cycle of out_q's new value and low otherwise. Never both high.
  - If f(a,b) != out_q and toggle_cnt < 2^CNT_W-1: toggle_cnt <= toggle_cnt+1. At max, toggle_cnt holds (saturates, no wrap).
- Inputs are required to be synchronous to clk; no synchronizer is provided.
  - Asynchronous inputs are the integrator's responsibility.
- Input changes that occur and revert between two clk edges are invisible to out_q, rise, fall and toggle_cnt.
- Reset asserted mid-operation clears all registered outputs immediately, including an active pulse.
- Delay semantics are simulation-only. The synthesized netlist implements out as a plain gate and is otherwise identical.

Test Plan:
- Truth table with timing, FUNC=0: {a,b} = 00, 01, 10, 11 at t = 0, 10, 20, 30 ns. Required: out stays 0 through t=30, goes to 1 at t=32 (T_RISE=2) and stays 1 until the end of the run.
- Fall delay: starting from {a,b}=11, change to 10 at time t. Required: out goes 1->0 at t+3 ns.
- Inertial filter: from 10, pulse b high for 1 ns. Required: out never rises.
- Clocked path (10 ns clk), rst_n released at t=0:
  - Stimulus: hold 11 for 3 cycles, then 00.
  - Required: out_q=1 after the first edge, with rise=1 for exactly that cycle.
  - Required: out_q=0 one edge after 00 is applied, with fall=1 for one cycle.
  - Required: toggle_cnt=2.
- Saturation: CNT_W=2, toggle a every cycle with b=1 for 6 cycles. Required: toggle_cnt counts 1,2,3 and then holds at 3.
- Async reset: assert rst_n=0 mid-cycle while out_q=1 and toggle_cnt=2.
  - Required: out_q=0 and toggle_cnt=0 immediately, without waiting for clk.
  - Required: out continues to follow f(a,b).
  - Required: after release, the first edge with {a,b}=11 gives rise=1.

Source files
------------

// File: rtl/uut_gate.sv
// uut_gate -- two-input logic gate with a delayed combinational output and a
// clocked observation path (registered value, edge pulses, toggle counter).
//
// Parameters:
//   FUNC   gate function: 0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR, others AND
//   T_RISE out 0->1 delay in ns (simulation only)
//   T_FALL out 1->0 delay in ns (simulation only)
//   CNT_W  width of toggle_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a, b       in   gate inputs (must be synchronous to clk)
//   out        out  combinational gate output, delayed by T_RISE/T_FALL
//   out_q      out  registered gate output
//   rise       out  one-cycle pulse when out_q goes 0->1
//   fall       out  one-cycle pulse when out_q goes 1->0
//   toggle_cnt out  saturating count of out_q transitions since reset

`timescale 1ns/1ps

module uut_gate #(
    parameter int FUNC   = 0,
    parameter int T_RISE = 2,
    parameter int T_FALL = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             out_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic f_raw;     // gate function of the undelayed inputs
    logic fv;        // f_raw with pessimistic unknown propagation
    logic f_rise_d;  // fv seen through the rise delay
    logic f_fall_d;  // fv seen through the fall delay

    always_comb begin
        f_raw = a & b;
        case (FUNC)
            1:       f_raw = a | b;
            2:       f_raw = a ^ b;
            3:       f_raw = ~(a & b);
            4:       f_raw = ~(a | b);
            5:       f_raw = ~(a ^ b);
            default: f_raw = a & b;
        endcase
    end

    // x^x is 0 for known values and X otherwise, so any unknown input forces
    // an unknown result even where the gate itself would mask it (e.g. 0&X).
    // Reduces to a plain gate in hardware.
    assign fv = f_raw ^ ((a ^ a) | (b ^ b));

    // Two single-delay paths combined with OR: a rising fv reaches out through
    // the short rise path, while a falling fv is held high by the fall path
    // until T_FALL has elapsed. Pulses shorter than a path's delay never
    // reach that path's output, so short input glitches are filtered.
    assign #(T_RISE) f_rise_d = fv;
    assign #(T_FALL) f_fall_d = fv;
    assign out = f_rise_d | f_fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            out_q <= fv;
            rise  <= fv & ~out_q;
            fall  <= ~fv & out_q;
            if ((fv != out_q) && (toggle_cnt != CNT_MAX)) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uut_gate.sv
// tb_uut_gate -- directed testbench for uut_gate.
// Instances: main (FUNC=0, CNT_W=8), sat (CNT_W=2) and one instance per FUNC
// value 0..6 for the combinational truth tables.

`timescale 1ns/1ps

module tb_uut_gate;

    logic       clk;
    logic       rst_n;

    // main instance
    logic       a, b;
    logic       out, out_q, rise, fall;
    logic [7:0] cnt;

    // saturation instance
    logic       sa, sb;
    logic       s_out, s_q, s_rise, s_fall;
    logic [1:0] s_cnt;

    // function instances
    logic       fa, fb;
    logic [6:0] f_out, f_q, f_rise, f_fall;
    logic [7:0] f_cnt [7];

    int n_tests = 0;
    int n_fail  = 0;

    logic watch     = 1'b0;
    logic rose_seen = 1'b0;

    uut_gate #(.FUNC(0), .T_RISE(2), .T_FALL(3), .CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .out(out), .out_q(out_q), .rise(rise), .fall(fall), .toggle_cnt(cnt)
    );

    uut_gate #(.FUNC(0), .T_RISE(2), .T_FALL(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(sa), .b(sb),
        .out(s_out), .out_q(s_q), .rise(s_rise), .fall(s_fall), .toggle_cnt(s_cnt)
    );

    for (genvar g = 0; g < 7; g++) begin : g_func
        uut_gate #(.FUNC(g), .T_RISE(2), .T_FALL(3), .CNT_W(8)) u_f (
            .clk(clk), .rst_n(rst_n), .a(fa), .b(fb),
            .out(f_out[g]), .out_q(f_q[g]), .rise(f_rise[g]), .fall(f_fall[g]),
            .toggle_cnt(f_cnt[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge out) begin
        if (watch) rose_seen = 1'b1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic at(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic check_regs(input string tag, input logic q, input logic r,
                              input logic f, input logic [7:0] c);
        check({tag, ".out_q"}, {31'd0, out_q}, {31'd0, q});
        check({tag, ".rise"},  {31'd0, rise},  {31'd0, r});
        check({tag, ".fall"},  {31'd0, fall},  {31'd0, f});
        check({tag, ".cnt"},   {24'd0, cnt},   {24'd0, c});
    endtask

    // Truth tables, bit index = {a,b}
    logic [3:0] tt [7];
    logic [3:0] tt_row;
    logic [1:0] ab;
    logic [1:0] sat_exp [6];

    initial begin
        tt[0] = 4'b1000;  // AND
        tt[1] = 4'b1110;  // OR
        tt[2] = 4'b0110;  // XOR
        tt[3] = 4'b0111;  // NAND
        tt[4] = 4'b0001;  // NOR
        tt[5] = 4'b1001;  // XNOR
        tt[6] = 4'b1000;  // out of range -> AND
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

        rst_n = 1'b0;
        a = 1'b0; b = 1'b0;
        sa = 1'b0; sb = 1'b0;
        fa = 1'b0; fb = 1'b0;

        // Reset state while the clock runs
        at(6);
        check_regs("reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // Truth table with timing: 00,01,10,11 at 0,10,20,30
        at(9);    check("tt00.out", {31'd0, out}, 32'd0);
        at(10);   b = 1'b1;
        at(19);   check("tt01.out", {31'd0, out}, 32'd0);
        at(20);   a = 1'b1; b = 1'b0;
        at(29);   check("tt10.out", {31'd0, out}, 32'd0);
        at(30);   a = 1'b1; b = 1'b1;
        at(31.9); check("rise_early.out", {31'd0, out}, 32'd0);
        at(32.1); check("rise_t32.out", {31'd0, out}, 32'd1);
        at(39);   check("rise_hold.out", {31'd0, out}, 32'd1);

        // Fall delay: 11 -> 10 at t=40, out falls at 43
        at(40);   b = 1'b0;
        at(42.9); check("fall_early.out", {31'd0, out}, 32'd1);
        at(43.1); check("fall_t43.out", {31'd0, out}, 32'd0);

        // Inertial filter: 1 ns pulse on b from 10
        at(49);   watch = 1'b1;
        at(50);   b = 1'b1;
        at(51);   b = 1'b0;
        at(59);   watch = 1'b0;
        check("inertial.rose", {31'd0, rose_seen}, 32'd0);
        check("inertial.out", {31'd0, out}, 32'd0);
        check_regs("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);

        // Combinational truth tables for every FUNC value
        for (int k = 0; k < 4; k++) begin
            ab = 2'(k);
            at(60.5 + 5.0 * k);
            fa = ab[1]; fb = ab[0];
            #4;
            for (int g = 0; g < 7; g++) begin
                tt_row = tt[g];
                check($sformatf("func%0d_ab%0d.out", g, k),
                      {31'd0, f_out[g]}, {31'd0, tt_row[ab]});
            end
        end

        // Clocked path: release reset, hold 11 for 3 cycles, then 00
        at(80);  a = 1'b0; b = 1'b0;
        at(86);  rst_n = 1'b1; a = 1'b1; b = 1'b1;
        at(94);  check_regs("pre_edge", 1'b0, 1'b0, 1'b0, 8'd0);
        at(96);  check_regs("cyc1", 1'b1, 1'b1, 1'b0, 8'd1);
        at(106); check_regs("cyc2", 1'b1, 1'b0, 1'b0, 8'd1);
        at(116); check_regs("cyc3", 1'b1, 1'b0, 1'b0, 8'd1);
        a = 1'b0; b = 1'b0;
        at(124); check("pre_fall.out_q", {31'd0, out_q}, 32'd1);
        at(126); check_regs("fall1", 1'b0, 1'b0, 1'b1, 8'd2);
        at(136); check_regs("fall2", 1'b0, 1'b0, 1'b0, 8'd2);
        a = 1'b1; b = 1'b1;
        at(146); check_regs("rise3", 1'b1, 1'b1, 1'b0, 8'd3);

        // Async reset mid-cycle, with rise pulse active
        at(148);   rst_n = 1'b0;
        at(148.5); check_regs("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        check("async_rst.out", {31'd0, out}, 32'd1);
        at(149);   a = 1'b0;
        at(153);   check("rst_follow0.out", {31'd0, out}, 32'd0);
        at(154);   a = 1'b1;
        at(157);   check("rst_follow1.out", {31'd0, out}, 32'd1);
        check_regs("rst_edge_held", 1'b0, 1'b0, 1'b0, 8'd0);
        at(158);   rst_n = 1'b1;
        at(164);   check("release.out_q", {31'd0, out_q}, 32'd0);
        at(166);   check_regs("release_edge", 1'b1, 1'b1, 1'b0, 8'd1);

        // Saturation on CNT_W=2: toggle a each cycle with b=1
        check("sat_start.cnt", {30'd0, s_cnt}, 32'd0);
        sb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sa = ~sa;
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.cnt", i), {30'd0, s_cnt}, {30'd0, sat_exp[i]});
            check($sformatf("sat%0d.out_q", i), {31'd0, s_q}, {31'd0, sa});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
